// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the instruction/data memory arbiter.
// Holds the bus request/response structs, the access-size constant and
// the small conversion functions used when a request is latched onto the
// shared memory port.
package mem_arbiter_pkg;

  // 4-byte access size used for every instruction fetch
  localparam logic [2:0] MSIZE4 = 3'b010;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } mreq_t;

  typedef struct packed {
    logic        ready;
    logic [63:0] data;
  } mresp_t;

  // Arbiter control states
  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } arb_state_t;

  // Which requester owns (or last owned) the shared port
  typedef enum logic {
    GNT_IBUS,
    GNT_DBUS
  } grant_t;

  // Instruction fetches are always 4-byte reads with no byte strobes
  function automatic mreq_t ibus_to_mreq(input ibus_req_t r);
    mreq_t m;
    m          = '0;
    m.valid    = 1'b1;
    m.is_write = 1'b0;
    m.addr     = r.addr;
    m.size     = MSIZE4;
    m.strobe   = 8'h00;
    m.data     = 64'h0;
    return m;
  endfunction

  // Data accesses are writes exactly when some byte strobe is set
  function automatic mreq_t dbus_to_mreq(input dbus_req_t r);
    mreq_t m;
    m          = '0;
    m.valid    = 1'b1;
    m.is_write = (r.strobe != 8'h00);
    m.addr     = r.addr;
    m.size     = r.size;
    m.strobe   = r.strobe;
    m.data     = r.data;
    return m;
  endfunction

  // Pick the 32-bit instruction word out of a 64-bit memory beat
  function automatic logic [31:0] select_word(input logic [63:0] addr,
                                              input logic [63:0] beat);
    return addr[2] ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// arb_watchdog: counts consecutive stalled cycles of an outstanding access.
// The count is cleared when a new grant is issued and advances on every
// enabled cycle; expired is raised during the cycle in which the count
// would reach LIMIT, so an access gets exactly LIMIT stalled cycles.
module arb_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Stall counter: restart on a new grant, hold once the limit is hit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = enable && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch bus and
// a data bus. One access is outstanding at a time; the winning request is
// latched and held on oreq until the memory answers or the watchdog aborts.
// Optional build macro ARB_ROUND_ROBIN_EN: when defined, simultaneous
// requests alternate against the previous grant; otherwise dbus always wins.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WDOG_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output mreq_t      oreq,
  input  mresp_t     oresp,
  output logic       bus_err
);

  arb_state_t state_q, state_d;
  grant_t     last_grant_q;
  grant_t     grant_sel;
  logic       take_grant;
  logic       resp_ok;
  logic       resp_abort;
  logic       wdog_en;
  logic       wdog_expired;
  mreq_t      oreq_q;
  ibus_resp_t iresp_q;
  dbus_resp_t dresp_q;
  logic       bus_err_q;

  // The watchdog only runs while an access is stalled on the memory side
  assign wdog_en = (state_q != IDLE) && !oresp.ready;

  arb_watchdog #(
    .LIMIT(WDOG_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (take_grant),
    .enable (wdog_en),
    .expired(wdog_expired)
  );

  // Choose a winner among the currently valid requesters
  always_comb begin
    grant_sel = GNT_IBUS;
    if (ireq.valid && dreq.valid) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_sel = (last_grant_q == GNT_IBUS) ? GNT_DBUS : GNT_IBUS;
`else
      grant_sel = GNT_DBUS;
`endif
    end else if (dreq.valid) begin
      grant_sel = GNT_DBUS;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: grant from IDLE, release on ready, or abort on watchdog expiry
  always_comb begin
    state_d    = state_q;
    take_grant = 1'b0;
    resp_ok    = 1'b0;
    resp_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (ireq.valid || dreq.valid) begin
          take_grant = 1'b1;
          state_d    = (grant_sel == GNT_DBUS) ? GRANT_D : GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (oresp.ready) begin
          resp_ok = 1'b1;
          state_d = IDLE;
        end else if (wdog_expired) begin
          resp_abort = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latched request, one-cycle response pulses, grant history and error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oreq_q       <= '0;
      iresp_q      <= '0;
      dresp_q      <= '0;
      bus_err_q    <= 1'b0;
      last_grant_q <= GNT_IBUS;
    end else begin
      iresp_q.addr_ok <= 1'b0;
      iresp_q.data_ok <= 1'b0;
      dresp_q.addr_ok <= 1'b0;
      dresp_q.data_ok <= 1'b0;

      if (take_grant) begin
        last_grant_q <= grant_sel;
        oreq_q       <= (grant_sel == GNT_DBUS) ? dbus_to_mreq(dreq)
                                                 : ibus_to_mreq(ireq);
      end

      if (resp_ok || resp_abort) begin
        oreq_q <= '0;
        if (state_q == GRANT_I) begin
          iresp_q.addr_ok <= resp_ok;
          iresp_q.data_ok <= 1'b1;
          iresp_q.data    <= resp_abort ? 32'hFFFF_FFFF
                                        : select_word(oreq_q.addr, oresp.data);
        end else begin
          dresp_q.addr_ok <= resp_ok;
          dresp_q.data_ok <= 1'b1;
          dresp_q.data    <= resp_abort ? 64'hFFFF_FFFF_FFFF_FFFF : oresp.data;
        end
      end

      if (resp_abort) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  assign oreq    = oreq_q;
  assign iresp   = iresp_q;
  assign dresp   = dresp_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level reference model.
// Honours ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int WDOG = 8;

  logic       clk = 1'b0;
  logic       rst;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  mreq_t      oreq;
  mresp_t     oresp;
  logic       bus_err;

  always #5 clk = ~clk;

  mem_arbiter #(
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ireq   (ireq),
    .iresp  (iresp),
    .dreq   (dreq),
    .dresp  (dresp),
    .oreq   (oreq),
    .oresp  (oresp),
    .bus_err(bus_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the port, how long it has waited, and what
  // every output should currently show
  int          owner;      // 0 none, 1 ibus, 2 dbus
  int          age;
  int          last;       // 1 ibus, 2 dbus
  mreq_t       m_oreq;
  logic        m_err;
  logic        m_i_ok, m_i_aok, m_d_ok, m_d_aok;
  logic [31:0] m_idata;
  logic [63:0] m_ddata;

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    owner   = 0;
    age     = 0;
    last    = 1;
    m_oreq  = '0;
    m_err   = 1'b0;
    m_i_ok  = 1'b0;
    m_i_aok = 1'b0;
    m_d_ok  = 1'b0;
    m_d_aok = 1'b0;
    m_idata = '0;
    m_ddata = '0;
  endtask

  // One rising edge of the reference model
  task automatic modelStep();
    logic want_d;
    logic abort;
    m_i_ok  = 1'b0;
    m_i_aok = 1'b0;
    m_d_ok  = 1'b0;
    m_d_aok = 1'b0;
    if (owner == 0) begin
      if (ireq.valid || dreq.valid) begin
        if (ireq.valid && dreq.valid) begin
`ifdef ARB_ROUND_ROBIN_EN
          want_d = (last == 1);
`else
          want_d = 1'b1;
`endif
        end else begin
          want_d = dreq.valid;
        end
        owner  = want_d ? 2 : 1;
        last   = owner;
        age    = 0;
        m_oreq = '0;
        m_oreq.valid = 1'b1;
        if (want_d) begin
          m_oreq.is_write = (dreq.strobe != 8'h00);
          m_oreq.addr     = dreq.addr;
          m_oreq.size     = dreq.size;
          m_oreq.strobe   = dreq.strobe;
          m_oreq.data     = dreq.data;
        end else begin
          m_oreq.addr = ireq.addr;
          m_oreq.size = MSIZE4;
        end
      end
    end else begin
      age++;
      if (oresp.ready || age == WDOG) begin
        abort = !oresp.ready;
        if (owner == 1) begin
          m_i_ok  = 1'b1;
          m_i_aok = !abort;
          if (abort) m_idata = 32'hFFFF_FFFF;
          else if (m_oreq.addr[2]) m_idata = oresp.data[63:32];
          else m_idata = oresp.data[31:0];
        end else begin
          m_d_ok  = 1'b1;
          m_d_aok = !abort;
          m_ddata = abort ? 64'hFFFF_FFFF_FFFF_FFFF : oresp.data;
        end
        if (abort) m_err = 1'b1;
        owner  = 0;
        m_oreq = '0;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("oreq", 256'(oreq), 256'(m_oreq));
    checkOutput("iresp_data_ok", 256'(iresp.data_ok), 256'(m_i_ok));
    if (!(m_i_ok && !m_i_aok)) checkOutput("iresp_addr_ok", 256'(iresp.addr_ok), 256'(m_i_aok));
    if (m_i_ok) checkOutput("iresp_data", 256'(iresp.data), 256'(m_idata));
    checkOutput("dresp_data_ok", 256'(dresp.data_ok), 256'(m_d_ok));
    if (!(m_d_ok && !m_d_aok)) checkOutput("dresp_addr_ok", 256'(dresp.addr_ok), 256'(m_d_aok));
    if (m_d_ok) checkOutput("dresp_data", 256'(dresp.data), 256'(m_ddata));
    checkOutput("bus_err", 256'(bus_err), 256'(m_err));
  endtask

  // Advance one clock: model follows the rising edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clk);
    if (!rst) modelReset();
    else modelStep();
    @(negedge clk);
    compareAll();
  endtask

  // Random request and memory-response pattern with percentage probabilities
  task automatic applyStimulus(input int p_i, input int p_d, input int p_rdy);
    ireq.valid   = ($urandom_range(99) < p_i);
    ireq.addr    = {$urandom, $urandom};
    dreq.valid   = ($urandom_range(99) < p_d);
    dreq.addr    = {$urandom, $urandom};
    dreq.size    = 3'($urandom_range(7));
    dreq.strobe  = ($urandom_range(1) == 1) ? 8'($urandom) : 8'h00;
    dreq.data    = {$urandom, $urandom};
    oresp.ready  = ($urandom_range(99) < p_rdy);
    oresp.data   = {$urandom, $urandom};
  endtask

  initial begin
    logic [31:0] seq;
    logic [31:0] exp_seq;
    int          grants;
    int          hit_at;

    rst   = 1'b0;
    ireq  = '0;
    dreq  = '0;
    oresp = '0;
    modelReset();
    repeat (2) @(negedge clk);
    compareAll();
    rst = 1'b1;

    // Both requesters held valid with memory always ready
    ireq.valid  = 1'b1;
    ireq.addr   = 64'h0000_0000_8000_0100;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h0000_0000_8000_0200;
    dreq.size   = 3'b011;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'h0123_4567_89AB_CDEF;
    oresp.ready = 1'b1;
    oresp.data  = 64'hAAAA_BBBB_CCCC_DDDD;
    seq    = '0;
    grants = 0;
    for (int k = 0; k < 12 && grants < 4; k++) begin
      tick();
      if (oreq.valid) begin
        seq = {seq[23:0], (oreq.is_write ? 8'h44 : 8'h49)};
        grants++;
      end
    end
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = "DIDI";
`else
    exp_seq = "DDDD";
`endif
    checkOutput("grant_order", 256'(seq), 256'(exp_seq));
    ireq.valid = 1'b0;
    dreq.valid = 1'b0;
    tick();
    oresp.ready = 1'b0;
    tick();

    // Lone instruction fetch of the upper word, requester drops valid after grant
    ireq.valid = 1'b1;
    ireq.addr  = 64'h0000_0000_8000_0004;
    tick();
    checkOutput("fetch_valid", 256'(oreq.valid), 256'(1'b1));
    checkOutput("fetch_addr", 256'(oreq.addr), 256'(64'h8000_0004));
    checkOutput("fetch_is_write", 256'(oreq.is_write), 256'(1'b0));
    ireq.valid = 1'b0;
    ireq.addr  = 64'h0000_0000_DEAD_0000;
    tick();
    oresp.ready = 1'b1;
    oresp.data  = 64'h1111_2222_3333_4444;
    tick();
    checkOutput("fetch_data_ok", 256'(iresp.data_ok), 256'(1'b1));
    checkOutput("fetch_data", 256'(iresp.data), 256'(32'h1111_2222));
    oresp.ready = 1'b0;
    tick();
    checkOutput("fetch_pulse_len", 256'(iresp.data_ok), 256'(1'b0));

    // Data write with fields copied, upstream changing during the grant
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h0000_0000_8000_0010;
    dreq.size   = MSIZE4;
    dreq.strobe = 8'h0F;
    dreq.data   = 64'h0000_0000_DEAD_BEEF;
    tick();
    checkOutput("write_is_write", 256'(oreq.is_write), 256'(1'b1));
    checkOutput("write_data", 256'(oreq.data), 256'(64'hDEAD_BEEF));
    dreq.valid = 1'b0;
    dreq.addr  = 64'h0000_0000_1234_5678;
    dreq.data  = 64'h5555_5555_5555_5555;
    tick();
    oresp.ready = 1'b1;
    oresp.data  = 64'h0;
    tick();
    oresp.ready = 1'b0;
    tick();

    // Memory never answers: watchdog abort after WDOG stalled cycles
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h0000_0000_8000_0040;
    dreq.strobe = 8'h00;
    tick();
    dreq.valid = 1'b0;
    hit_at = -1;
    for (int k = 1; k <= WDOG + 4; k++) begin
      tick();
      if (dresp.data_ok && hit_at < 0) hit_at = k;
    end
    checkOutput("wdog_latency", 256'(hit_at), 256'(WDOG));
    checkOutput("wdog_bus_err", 256'(bus_err), 256'(1'b1));
    ireq.valid  = 1'b1;
    ireq.addr   = 64'h0000_0000_8000_0080;
    oresp.ready = 1'b1;
    oresp.data  = 64'h9999_8888_7777_6666;
    tick();
    ireq.valid = 1'b0;
    tick();
    checkOutput("post_abort_data", 256'(iresp.data), 256'(32'h7777_6666));
    oresp.ready = 1'b0;
    tick();

    // Reset asserted two cycles into a data grant
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h0000_0000_8000_0100;
    dreq.strobe = 8'h01;
    tick();
    dreq.valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_oreq_valid", 256'(oreq.valid), 256'(1'b0));
    checkOutput("rst_bus_err", 256'(bus_err), 256'(1'b0));
    oresp.ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    dreq.valid = 1'b1;
    oresp.ready = 1'b0;
    tick();
    dreq.valid  = 1'b0;
    oresp.ready = 1'b1;
    tick();
    oresp.ready = 1'b0;
    tick();

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      applyStimulus(40, 40, 35);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
